xb_pipe_reg: RTL and testbench

//   Registered, parametrised successor of the 5x5 crossbar main stage: NP inputs x NP outputs,
//   one-hot select per output from the switch allocator, one output register stage per port

---
 rtl/xb_pipe_reg.sv | 117 +++++++++++
 tb/tb_xb_pipe_reg.sv | 329 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/xb_pipe_reg.sv
// NP x NP registered crossbar with one-hot per-output select, valid/ready
// backpressure, optional atomic multicast, flit counters and error flags.
module xb_pipe_reg #(
    parameter int NP    = 5,
    parameter int DW    = 32,
    parameter int CW    = 16,
    parameter int MCAST = 0
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic [NP*NP-1:0] sel,
    input  logic [NP*DW-1:0] data_in,
    input  logic [NP-1:0]    valid_in,
    output logic [NP-1:0]    in_ready,
    output logic [NP*DW-1:0] data_out,
    output logic [NP-1:0]    valid_out,
    input  logic [NP-1:0]    ready_out,
    output logic [NP-1:0]    err_multi,
    input  logic             cnt_clr,
    output logic [NP*CW-1:0] flit_cnt
);

    logic [NP-1:0]    r_valid;
    logic [NP*DW-1:0] r_data;
    logic [NP-1:0]    r_err;
    logic [NP*CW-1:0] r_cnt;

    logic [NP-1:0]    w_row [NP];
    logic [NP-1:0]    w_dst [NP];
    logic [NP-1:0]    w_free;
    logic [NP-1:0]    w_multi;
    logic [NP-1:0]    w_legal;
    logic [NP-1:0]    w_mc;
    logic [NP-1:0]    w_rdy;
    logic [NP-1:0]    w_load;
    logic [NP*DW-1:0] w_mux;

    always_comb begin
        for (int o = 0; o < NP; o++) begin
            w_row[o]   = sel[o*NP +: NP];
            w_free[o]  = !r_valid[o] || ready_out[o];
            w_multi[o] = |(w_row[o] & (w_row[o] - NP'(1)));
            w_legal[o] = (|w_row[o]) && !w_multi[o];
        end
    end

    // An input is ready only if every destination register can load it.
    always_comb begin
        for (int i = 0; i < NP; i++) begin
            w_dst[i] = '0;
            for (int o = 0; o < NP; o++) begin
                w_dst[i][o] = w_legal[o] && w_row[o][i];
            end
            w_mc[i]  = |(w_dst[i] & (w_dst[i] - NP'(1)));
            w_rdy[i] = rstn && (|w_dst[i])
                     && ((w_dst[i] & ~w_free) == '0)
                     && ((MCAST != 0) || !w_mc[i]);
        end
    end

    always_comb begin
        w_load = '0;
        w_mux  = '0;
        for (int o = 0; o < NP; o++) begin
            for (int i = 0; i < NP; i++) begin
                if (w_legal[o] && w_row[o][i]) begin
                    w_load[o]         = valid_in[i] && w_rdy[i];
                    w_mux[o*DW +: DW] = data_in[i*DW +: DW];
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_valid <= '0;
            r_data  <= '0;
        end else begin
            for (int o = 0; o < NP; o++) begin
                if (w_load[o]) begin
                    r_valid[o]         <= 1'b1;
                    r_data[o*DW +: DW] <= w_mux[o*DW +: DW];
                end else if (ready_out[o]) begin
                    r_valid[o] <= 1'b0;
                end
            end
        end
    end

    // Clear has priority over same-cycle increments and error captures.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_err <= '0;
            r_cnt <= '0;
        end else if (cnt_clr) begin
            r_err <= '0;
            r_cnt <= '0;
        end else begin
            for (int o = 0; o < NP; o++) begin
                if (w_multi[o]) begin
                    r_err[o] <= 1'b1;
                end
                if (r_valid[o] && ready_out[o]
                    && (r_cnt[o*CW +: CW] != '1)) begin
                    r_cnt[o*CW +: CW] <= r_cnt[o*CW +: CW] + CW'(1);
                end
            end
        end
    end

    assign in_ready  = w_rdy;
    assign data_out  = r_data;
    assign valid_out = r_valid;
    assign err_multi = r_err;
    assign flit_cnt  = r_cnt;

endmodule

// File: tb/tb_xb_pipe_reg.sv
// Scoreboard bench for xb_pipe_reg: multicast instance (CW=4) plus a
// unicast-only instance used for the blocked-multicast case.
module tb_xb_pipe_reg;

    localparam int NP = 5;
    localparam int DW = 32;
    localparam int CW = 4;

    logic             clk;
    logic             rstn;
    logic [NP*NP-1:0] sel;
    logic [NP*DW-1:0] data_in;
    logic [NP-1:0]    valid_in;
    logic [NP-1:0]    in_ready;
    logic [NP*DW-1:0] data_out;
    logic [NP-1:0]    valid_out;
    logic [NP-1:0]    ready_out;
    logic [NP-1:0]    err_multi;
    logic             cnt_clr;
    logic [NP*CW-1:0] flit_cnt;

    logic [NP*NP-1:0] b_sel;
    logic [NP*DW-1:0] b_data_in;
    logic [NP-1:0]    b_valid_in;
    logic [NP-1:0]    b_in_ready;
    logic [NP*DW-1:0] b_data_out;
    logic [NP-1:0]    b_valid_out;
    logic [NP-1:0]    b_ready_out;
    logic [NP-1:0]    b_err_multi;
    logic             b_cnt_clr;
    logic [NP*16-1:0] b_flit_cnt;

    xb_pipe_reg #(.NP(NP), .DW(DW), .CW(CW), .MCAST(1)) u_dut (
        .clk(clk), .rstn(rstn), .sel(sel), .data_in(data_in),
        .valid_in(valid_in), .in_ready(in_ready), .data_out(data_out),
        .valid_out(valid_out), .ready_out(ready_out),
        .err_multi(err_multi), .cnt_clr(cnt_clr), .flit_cnt(flit_cnt)
    );

    xb_pipe_reg #(.NP(NP), .DW(DW), .CW(16), .MCAST(0)) u_dut_uc (
        .clk(clk), .rstn(rstn), .sel(b_sel), .data_in(b_data_in),
        .valid_in(b_valid_in), .in_ready(b_in_ready),
        .data_out(b_data_out), .valid_out(b_valid_out),
        .ready_out(b_ready_out), .err_multi(b_err_multi),
        .cnt_clr(b_cnt_clr), .flit_cnt(b_flit_cnt)
    );

    int n_tot = 0;
    int n_bad = 0;
    logic [DW-1:0] q [NP][$];

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got=timeout exp=finish");
        $fatal(1);
    end

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
        n_tot++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [DW-1:0] dout(input int o);
        return data_out[o*DW +: DW];
    endfunction

    function automatic logic [CW-1:0] cnt(input int o);
        return flit_cnt[o*CW +: CW];
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic mid();
        @(negedge clk);
    endtask

    task automatic route(input int o, input int i);
        sel[o*NP+i] = 1'b1;
    endtask

    task automatic put(input int i, input logic [DW-1:0] d);
        valid_in[i]          = 1'b1;
        data_in[i*DW +: DW]  = d;
    endtask

    task automatic idle();
        sel      = '0;
        valid_in = '0;
    endtask

    // Every handshake on an output must carry the oldest expected flit.
    always @(negedge clk) begin
        for (int o = 0; o < NP; o++) begin
            if (valid_out[o] && ready_out[o]) begin
                if (q[o].size() == 0)
                    chk($sformatf("sb_extra_o%0d", o), 1, 0);
                else
                    chk($sformatf("sb_o%0d", o), dout(o), q[o].pop_front());
            end
        end
    end

    initial begin
        int sz;
        rstn = 1'b0;
        sel = '0; data_in = '0; valid_in = '0;
        ready_out = '1; cnt_clr = 1'b0;
        b_sel = '0; b_data_in = '0; b_valid_in = '0;
        b_ready_out = '1; b_cnt_clr = 1'b0;
        route(0, 0);
        put(0, 32'h11);
        #2;
        chk("rst_valid", valid_out, 0);
        chk("rst_dout", |data_out, 0);
        chk("rst_err", err_multi, 0);
        chk("rst_cnt", flit_cnt, 0);
        chk("rst_in_ready", in_ready, 0);
        idle();
        #5 rstn = 1'b1;
        tick();

        // unicast i2 -> o0
        route(0, 2);
        put(2, 32'hA5);
        mid();
        chk("uc_in_ready", in_ready, 5'b00100);
        q[0].push_back(32'hA5);
        tick();
        chk("uc_valid", valid_out, 5'b00001);
        chk("uc_data", dout(0), 32'hA5);
        idle();
        tick();
        chk("uc_cnt", cnt(0), 1);
        chk("uc_drain", valid_out, 0);

        // backpressure on o1 while i3 keeps targeting it
        route(1, 3);
        put(3, 32'hB1);
        mid();
        chk("bp_rdy0", in_ready[3], 1);
        q[1].push_back(32'hB1);
        tick();
        chk("bp_load", valid_out[1], 1);
        ready_out[1] = 1'b0;
        put(3, 32'hB2);
        for (int k = 0; k < 3; k++) begin
            mid();
            chk("bp_stall_rdy", in_ready[3], 0);
            tick();
            chk("bp_hold_data", dout(1), 32'hB1);
            chk("bp_hold_valid", valid_out[1], 1);
        end
        ready_out[1] = 1'b1;
        mid();
        chk("bp_release_rdy", in_ready[3], 1);
        q[1].push_back(32'hB2);
        tick();
        chk("bp_nogap_valid", valid_out[1], 1);
        chk("bp_nogap_data", dout(1), 32'hB2);
        idle();
        tick();
        chk("bp_cnt", cnt(1), 2);

        // multicast i0 -> o1,o3 with o3 stalled
        route(3, 4);
        put(4, 32'hC0);
        mid();
        chk("mc_pre_rdy", in_ready[4], 1);
        q[3].push_back(32'hC0);
        tick();
        chk("mc_pre_valid", valid_out[3], 1);
        idle();
        ready_out[3] = 1'b0;
        route(1, 0);
        route(3, 0);
        put(0, 32'hD0);
        b_sel[1*NP+0] = 1'b1;
        b_sel[3*NP+0] = 1'b1;
        b_valid_in[0] = 1'b1;
        for (int k = 0; k < 2; k++) begin
            mid();
            chk("mc_stall_rdy", in_ready[0], 0);
            chk("mc0_block_rdy", b_in_ready[0], 0);
            tick();
            chk("mc_no_load", valid_out[1], 0);
            chk("mc_hold3", dout(3), 32'hC0);
        end
        ready_out[3] = 1'b1;
        mid();
        chk("mc_free_rdy", in_ready[0], 1);
        chk("mc0_block_rdy2", b_in_ready[0], 0);
        q[1].push_back(32'hD0);
        q[3].push_back(32'hD0);
        tick();
        chk("mc_both", valid_out & 5'b01010, 5'b01010);
        chk("mc0_no_load", b_valid_out, 0);
        idle();
        tick();
        chk("mc_cnt1", cnt(1), 3);
        chk("mc_cnt3", cnt(3), 2);

        // illegal select on o4
        sel[4*NP+1] = 1'b1;
        sel[4*NP+2] = 1'b1;
        put(1, 32'hE1);
        put(2, 32'hE2);
        mid();
        chk("ill_rdy", in_ready, 0);
        tick();
        chk("ill_valid", valid_out[4], 0);
        chk("ill_err", err_multi, 5'b10000);
        idle();
        tick();
        chk("ill_sticky", err_multi, 5'b10000);
        sel[4*NP+1] = 1'b1;
        sel[4*NP+2] = 1'b1;
        cnt_clr = 1'b1;
        tick();
        chk("ill_clr_err", err_multi, 0);
        chk("ill_clr_cnt", flit_cnt, 0);
        cnt_clr = 1'b0;
        idle();
        tick();
        chk("ill_after_clr", err_multi, 0);

        // 20 back-to-back flits on o2, counter saturates at 15
        for (int k = 0; k < 20; k++) begin
            route(2, 1);
            put(1, 32'h100 + k);
            mid();
            chk("sat_rdy", in_ready[1], 1);
            q[2].push_back(32'h100 + k);
            tick();
            chk("sat_valid", valid_out[2], 1);
        end
        idle();
        tick();
        tick();
        chk("sat_cnt", cnt(2), 15);
        cnt_clr = 1'b1;
        tick();
        cnt_clr = 1'b0;
        chk("sat_clr", cnt(2), 0);
        route(2, 1);
        put(1, 32'hE0);
        mid();
        q[2].push_back(32'hE0);
        tick();
        idle();
        cnt_clr = 1'b1;
        tick();
        cnt_clr = 1'b0;
        chk("clr_vs_hs", cnt(2), 0);
        tick();
        chk("clr_vs_hs_hold", cnt(2), 0);

        // async reset with every output valid and stalled
        route(0, 1);
        put(1, 32'h60);
        mid();
        q[0].push_back(32'h60);
        tick();
        idle();
        tick();
        chk("pre_rst_cnt", cnt(0), 1);
        for (int k = 0; k < NP; k++) begin
            route(k, k);
            put(k, 32'hF0 + k);
        end
        mid();
        chk("all_rdy", in_ready, 5'h1f);
        for (int k = 0; k < NP; k++)
            q[k].push_back(32'hF0 + k);
        tick();
        chk("all_valid", valid_out, 5'h1f);
        idle();
        ready_out = '0;
        tick();
        chk("all_stalled", valid_out, 5'h1f);
        route(0, 0);
        put(0, 32'h99);
        #2 rstn = 1'b0;
        #1;
        chk("arst_valid", valid_out, 0);
        chk("arst_cnt", flit_cnt, 0);
        chk("arst_dout", |data_out, 0);
        chk("arst_rdy", in_ready, 0);
        for (int k = 0; k < NP; k++)
            q[k].delete();
        idle();
        rstn = 1'b1;
        ready_out = '1;
        route(0, 2);
        put(2, 32'h77);
        mid();
        chk("post_rst_rdy", in_ready, 5'b00100);
        q[0].push_back(32'h77);
        tick();
        chk("post_rst_valid", valid_out, 5'b00001);
        chk("post_rst_data", dout(0), 32'h77);
        idle();
        tick();
        chk("post_rst_cnt", cnt(0), 1);

        tick();
        sz = 0;
        for (int k = 0; k < NP; k++)
            sz += q[k].size();
        chk("sb_empty", sz, 0);
        chk("mc0_never_valid", b_valid_out, 0);
        chk("mc0_never_rdy", b_in_ready[0], 0);

        $display("test done: total=%0d bad=%0d", n_tot, n_bad);
        $finish;
    end

endmodule
